// File: rtl/freq_pkg.sv
// freq_pkg: definitions shared by the frequency generator and the frequency
// measurement block.
//   freq_state_e : generator FSM states (IDLE, HIGH, LOW)
//   FREQ_WIDTH   : default period/high-time counter width
//   FREQ_BURST_W : default burst-length field width
//   freq_cfg_t   : config record {period, high, burst} at the default widths
//   MIN_PERIOD, MIN_HIGH : clamp floors applied to captured config
package freq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } freq_state_e;

    localparam int FREQ_WIDTH   = 16;
    localparam int FREQ_BURST_W = 8;
    localparam int MIN_PERIOD   = 2;
    localparam int MIN_HIGH     = 1;

    typedef struct packed {
        logic [FREQ_WIDTH-1:0]   period;
        logic [FREQ_WIDTH-1:0]   high;
        logic [FREQ_BURST_W-1:0] burst;
    } freq_cfg_t;

endpackage

// File: rtl/freq_gen_if.sv
// freq_gen_if: config handshake, run control and waveform outputs of freq_gen.
//   master : drives cfg_valid/cfg_period/cfg_high/cfg_burst/start/stop,
//            observes cfg_ready/wave_out/busy/done
//   slave  : the generator side
// Optional macro FREQ_GEN_SYNC_EN adds sync_tick (pulse on each wave_out rise).
interface freq_gen_if
    import freq_pkg::*;
#(
    parameter int WIDTH   = FREQ_WIDTH,
    parameter int BURST_W = FREQ_BURST_W
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [WIDTH-1:0]   cfg_period;
    logic [WIDTH-1:0]   cfg_high;
    logic [BURST_W-1:0] cfg_burst;
    logic               start;
    logic               stop;
    logic               wave_out;
    logic               busy;
    logic               done;
`ifdef FREQ_GEN_SYNC_EN
    logic               sync_tick;

    modport master (
        output cfg_valid, cfg_period, cfg_high, cfg_burst, start, stop,
        input  cfg_ready, wave_out, busy, done, sync_tick
    );
    modport slave (
        input  cfg_valid, cfg_period, cfg_high, cfg_burst, start, stop,
        output cfg_ready, wave_out, busy, done, sync_tick
    );
`else
    modport master (
        output cfg_valid, cfg_period, cfg_high, cfg_burst, start, stop,
        input  cfg_ready, wave_out, busy, done
    );
    modport slave (
        input  cfg_valid, cfg_period, cfg_high, cfg_burst, start, stop,
        output cfg_ready, wave_out, busy, done
    );
`endif
endinterface

// File: rtl/freq_cfg_shadow.sv
// freq_cfg_shadow: config handshake, clamp, shadow register and active config.
//   in_valid/in_ready      : handshake; ready whenever the shadow is empty
//   in_period/high/burst   : raw config, clamped on capture
//   apply_ok               : generator is at a point where config may change
//   act_period/act_high    : config in force for the current period
//   eff_burst              : burst length of the config in force after this edge
module freq_cfg_shadow
    import freq_pkg::*;
#(
    parameter int WIDTH   = FREQ_WIDTH,
    parameter int BURST_W = FREQ_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_period,
    input  logic [WIDTH-1:0]   in_high,
    input  logic [BURST_W-1:0] in_burst,
    input  logic               apply_ok,
    output logic [WIDTH-1:0]   act_period,
    output logic [WIDTH-1:0]   act_high,
    output logic [BURST_W-1:0] eff_burst
);
    logic               full_q, full_d;
    logic [WIDTH-1:0]   sh_period_q, sh_period_d, sh_high_q, sh_high_d;
    logic [BURST_W-1:0] sh_burst_q, sh_burst_d;
    logic [WIDTH-1:0]   act_period_q, act_period_d, act_high_q, act_high_d;
    logic [BURST_W-1:0] act_burst_q, act_burst_d;
    logic [WIDTH-1:0]   p_clamp, h_clamp;
    logic               xfer, apply;

    // Period is clamped first so the high-time ceiling uses the final period.
    always_comb begin
        p_clamp = in_period;
        if (in_period < WIDTH'(MIN_PERIOD)) p_clamp = WIDTH'(MIN_PERIOD);
        h_clamp = in_high;
        if (in_high == '0) h_clamp = WIDTH'(MIN_HIGH);
        if (h_clamp >= p_clamp) h_clamp = p_clamp - WIDTH'(1);
    end

    assign in_ready = !full_q;
    assign xfer     = in_valid && !full_q;
    assign apply    = full_q && apply_ok;
    assign eff_burst  = apply ? sh_burst_q : act_burst_q;
    assign act_period = act_period_q;
    assign act_high   = act_high_q;

    always_comb begin
        full_d       = xfer || (full_q && !apply);
        sh_period_d  = xfer ? p_clamp  : sh_period_q;
        sh_high_d    = xfer ? h_clamp  : sh_high_q;
        sh_burst_d   = xfer ? in_burst : sh_burst_q;
        act_period_d = apply ? sh_period_q : act_period_q;
        act_high_d   = apply ? sh_high_q   : act_high_q;
        act_burst_d  = apply ? sh_burst_q  : act_burst_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q       <= 1'b0;
            sh_period_q  <= WIDTH'(MIN_PERIOD);
            sh_high_q    <= WIDTH'(MIN_HIGH);
            sh_burst_q   <= '0;
            act_period_q <= WIDTH'(MIN_PERIOD);
            act_high_q   <= WIDTH'(MIN_HIGH);
            act_burst_q  <= '0;
        end else begin
            full_q       <= full_d;
            sh_period_q  <= sh_period_d;
            sh_high_q    <= sh_high_d;
            sh_burst_q   <= sh_burst_d;
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            act_burst_q  <= act_burst_d;
        end
    end
endmodule

// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave generator, free-running or N-period burst.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : freq_gen_if slave (config handshake, start/stop, wave_out,
//              busy, done)
// Optional macro FREQ_GEN_SYNC_EN adds bus.sync_tick, a one-cycle pulse
// coincident with every wave_out rising edge.
module freq_gen
    import freq_pkg::*;
#(
    parameter int WIDTH   = FREQ_WIDTH,
    parameter int BURST_W = FREQ_BURST_W
) (
    input  logic      clk,
    input  logic      rst,
    freq_gen_if.slave bus
);
    freq_state_e        state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] burst_rem_q, burst_rem_d;
    logic               stop_pend_q, stop_pend_d;
    logic               wave_q, wave_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   act_period, act_high;
    logic [BURST_W-1:0] eff_burst;
    logic               period_end, finish, apply_ok;

    freq_cfg_shadow #(.WIDTH(WIDTH), .BURST_W(BURST_W)) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (bus.cfg_valid),
        .in_ready   (bus.cfg_ready),
        .in_period  (bus.cfg_period),
        .in_high    (bus.cfg_high),
        .in_burst   (bus.cfg_burst),
        .apply_ok   (apply_ok),
        .act_period (act_period),
        .act_high   (act_high),
        .eff_burst  (eff_burst)
    );

    // cnt_q counts cycles from the start of the period; LOW ends at P-1.
    // burst_rem_q is 0 in continuous mode and never reaches 0 otherwise
    // until the final period, so ==1 marks the last burst period.
    // A stop arriving on the last LOW cycle still lets that period finish.
    assign period_end = (state_q == LOW) && (cnt_q == act_period - WIDTH'(1));
    assign finish     = period_end &&
                        (stop_pend_q || bus.stop || burst_rem_q == BURST_W'(1));
    assign apply_ok   = (state_q == IDLE) || (period_end && !finish);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_rem_d = burst_rem_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // stop in IDLE (alone or alongside start) is discarded.
                if (bus.start) begin
                    state_d     = HIGH;
                    cnt_d       = '0;
                    burst_rem_d = eff_burst;
                    stop_pend_d = 1'b0;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + WIDTH'(1);
                if (bus.stop) stop_pend_d = 1'b1;
                if (cnt_q == act_high - WIDTH'(1)) state_d = LOW;
            end
            LOW: begin
                cnt_d = cnt_q + WIDTH'(1);
                if (bus.stop) stop_pend_d = 1'b1;
                if (period_end) begin
                    cnt_d = '0;
                    if (finish) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                        burst_rem_d = '0;
                    end else begin
                        state_d = HIGH;
                        if (burst_rem_q != '0) burst_rem_d = burst_rem_q - BURST_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        wave_d = (state_d == HIGH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            burst_rem_q <= '0;
            stop_pend_q <= 1'b0;
            wave_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            burst_rem_q <= burst_rem_d;
            stop_pend_q <= stop_pend_d;
            wave_q      <= wave_d;
            done_q      <= done_d;
        end
    end

    assign bus.wave_out = wave_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;

`ifdef FREQ_GEN_SYNC_EN
    logic sync_q, sync_d;

    // HIGH is entered only from IDLE or LOW, so every entry is a rising edge.
    assign sync_d = (state_d == HIGH) && (state_q != HIGH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 1'b0;
        else     sync_q <= sync_d;
    end

    assign bus.sync_tick = sync_q;
`endif
endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: directed self-checking bench for freq_gen. Inputs are driven
// and outputs sampled on the falling edge; sample i is taken i rising edges
// after the edge that samples start.
module tb_freq_gen;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    freq_gen_if #(.WIDTH(16), .BURST_W(8)) bus ();

    freq_gen #(.WIDTH(16), .BURST_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef FREQ_GEN_SYNC_EN
    int   rises = 0;
    int   ticks = 0;
    logic prev_w = 1'b0;
    always @(negedge clk) begin
        if (bus.wave_out && !prev_w) rises++;
        if (bus.sync_tick) ticks++;
        prev_w = bus.wave_out;
    end
`endif

    // Offers one config while the shadow is empty and waits for the IDLE apply.
    task automatic send_cfg(input int p, input int h, input int b);
        @(negedge clk);
        bus.cfg_valid  = 1'b1;
        bus.cfg_period = 16'(p);
        bus.cfg_high   = 16'(h);
        bus.cfg_burst  = 8'(b);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.wave_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset wave/busy/done/ready=%b%b%b%b want 0001",
                     bus.wave_out, bus.busy, bus.done, bus.cfg_ready);
        end
`ifdef FREQ_GEN_SYNC_EN
        checks++;
        if (bus.sync_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset sync_tick=%b want 0", bus.sync_tick);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_continuous();
        logic ew, eb, ed;
        send_cfg(10, 3, 0);
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 62; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            ew = (i <= 60) && (((i - 1) % 10) < 3);
            eb = (i <= 60);
            ed = (i == 61);
            checks++;
            if (bus.wave_out !== ew || bus.busy !== eb || bus.done !== ed) begin
                errors++;
                $display("FAIL continuous i=%0d wave/busy/done=%b%b%b want %b%b%b",
                         i, bus.wave_out, bus.busy, bus.done, ew, eb, ed);
            end
            bus.stop = (i == 51);
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_burst();
        logic ew, eb, ed;
        send_cfg(4, 2, 3);
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            ew = (i <= 12) && (((i - 1) % 4) < 2);
            eb = (i <= 12);
            ed = (i == 13);
            checks++;
            if (bus.wave_out !== ew || bus.busy !== eb || bus.done !== ed) begin
                errors++;
                $display("FAIL burst i=%0d wave/busy/done=%b%b%b want %b%b%b",
                         i, bus.wave_out, bus.busy, bus.done, ew, eb, ed);
            end
        end
    endtask

    task automatic test_clamp();
        logic ew, eb, ed;
        // P=1,H=0 runs as 1 high / 1 low, two periods.
        send_cfg(1, 0, 2);
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            ew = (i <= 4) && (((i - 1) % 2) < 1);
            eb = (i <= 4);
            ed = (i == 5);
            checks++;
            if (bus.wave_out !== ew || bus.busy !== eb || bus.done !== ed) begin
                errors++;
                $display("FAIL clamp_p1h0 i=%0d wave/busy/done=%b%b%b want %b%b%b",
                         i, bus.wave_out, bus.busy, bus.done, ew, eb, ed);
            end
        end
        // P=5,H=9 runs as 4 high / 1 low, one period.
        send_cfg(5, 9, 1);
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            ew = (i <= 4);
            eb = (i <= 5);
            ed = (i == 6);
            checks++;
            if (bus.wave_out !== ew || bus.busy !== eb || bus.done !== ed) begin
                errors++;
                $display("FAIL clamp_h_ge_p i=%0d wave/busy/done=%b%b%b want %b%b%b",
                         i, bus.wave_out, bus.busy, bus.done, ew, eb, ed);
            end
        end
    endtask

    task automatic test_reconfig();
        logic ew, eb, ed, er;
        send_cfg(8, 4, 0);
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            ew = (i <= 8) ? (i <= 4) : ((i <= 20) && (((i - 9) % 6) < 1));
            eb = (i <= 20);
            ed = (i == 21);
            checks++;
            if (bus.wave_out !== ew || bus.busy !== eb || bus.done !== ed) begin
                errors++;
                $display("FAIL reconfig i=%0d wave/busy/done=%b%b%b want %b%b%b",
                         i, bus.wave_out, bus.busy, bus.done, ew, eb, ed);
            end
            if (i == 6 || i == 7 || i == 8 || i == 9) begin
                er = (i == 6 || i == 9);
                checks++;
                if (bus.cfg_ready !== er) begin
                    errors++;
                    $display("FAIL reconfig_ready i=%0d ready=%b want %b", i, bus.cfg_ready, er);
                end
            end
            // Mid-LOW of the first period: offer P=6,H=1.
            bus.cfg_valid  = (i == 6);
            bus.cfg_period = 16'd6;
            bus.cfg_high   = 16'd1;
            bus.cfg_burst  = 8'd0;
            bus.stop       = (i == 15);
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_stop();
        logic ew, eb, ed;
`ifdef FREQ_GEN_SYNC_EN
        int r0, t0;
`endif
        send_cfg(10, 5, 0);
`ifdef FREQ_GEN_SYNC_EN
        r0 = rises;
        t0 = ticks;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            ew = (i <= 5);
            eb = (i <= 10);
            ed = (i == 11);
            checks++;
            if (bus.wave_out !== ew || bus.busy !== eb || bus.done !== ed) begin
                errors++;
                $display("FAIL stop i=%0d wave/busy/done=%b%b%b want %b%b%b",
                         i, bus.wave_out, bus.busy, bus.done, ew, eb, ed);
            end
            bus.stop = (i == 3);
        end
        bus.stop = 1'b0;
`ifdef FREQ_GEN_SYNC_EN
        checks++;
        if (rises - r0 != 1 || ticks - t0 != 1) begin
            errors++;
            $display("FAIL sync_tick rises=%0d ticks=%0d want 1 and 1", rises - r0, ticks - t0);
        end
        checks++;
        if (rises != ticks) begin
            errors++;
            $display("FAIL sync_total rises=%0d ticks=%0d want equal", rises, ticks);
        end
`endif
    endtask

    task automatic test_start_stop();
        logic ew, eb, ed;
        send_cfg(4, 2, 0);
        // stop alone in IDLE does nothing.
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_stop busy/done=%b%b want 00", bus.busy, bus.done);
        end
        // start and stop together: start wins, generator runs on.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            ew = (i <= 12) && (((i - 1) % 4) < 2);
            eb = (i <= 12);
            ed = (i == 13);
            checks++;
            if (bus.wave_out !== ew || bus.busy !== eb || bus.done !== ed) begin
                errors++;
                $display("FAIL start_stop i=%0d wave/busy/done=%b%b%b want %b%b%b",
                         i, bus.wave_out, bus.busy, bus.done, ew, eb, ed);
            end
            bus.stop = (i == 9);
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic ew, eb, ed;
        send_cfg(10, 3, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // Leave a config pending in the shadow while running.
        bus.cfg_valid  = 1'b1;
        bus.cfg_period = 16'd6;
        bus.cfg_high   = 16'd2;
        bus.cfg_burst  = 8'd0;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        checks++;
        if (bus.cfg_ready !== 1'b0 || bus.wave_out !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre ready/wave=%b%b want 01", bus.cfg_ready, bus.wave_out);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.wave_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_rst wave/busy/done/ready=%b%b%b%b want 0001",
                     bus.wave_out, bus.busy, bus.done, bus.cfg_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        // Reset config (P=2,H=1) must be in force; the pending one is gone.
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            ew = (i <= 4) && ((i % 2) == 1);
            eb = (i <= 4);
            ed = (i == 5);
            checks++;
            if (bus.wave_out !== ew || bus.busy !== eb || bus.done !== ed) begin
                errors++;
                $display("FAIL midrun_after i=%0d wave/busy/done=%b%b%b want %b%b%b",
                         i, bus.wave_out, bus.busy, bus.done, ew, eb, ed);
            end
            bus.stop = (i == 3);
        end
        bus.stop = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_period = '0;
        bus.cfg_high   = '0;
        bus.cfg_burst  = '0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        test_reset();
        test_continuous();
        test_burst();
        test_clamp();
        test_reconfig();
        test_stop();
        test_start_stop();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
